adder_rr_scheduler: RTL and testbench
=====================================

# adder_rr_scheduler

Round-robin scheduler that shares one registered WIDTH-bit adder among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The scheduler grants one requester per accepted transaction, computes a + b with carry-out, and returns the result tagged with the requester index on a single valid/ready response channel. It sits between the requesting datapath blocks and the shared arithmetic resource.

## Interface
- WIDTH, 8, operand and sum width in bits (>= 1)
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), requester-index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronous to clk externally
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  packed operand B, same packing
- req_ready  out  NREQ  one-hot (or zero) grant/ready, combinational
- rsp_valid  out  1  result valid (registered)
- rsp_ready  in  1  downstream accepts result
- rsp_id  out  IDW  index of requester that produced the result
- rsp_sum  out  WIDTH  (a + b) mod 2^WIDTH
- rsp_carry  out  1  bit WIDTH of a + b
- busy  out  1  equals rsp_valid (result held, not yet consumed)

## Operation
- State machine: EMPTY (no result held) and FULL (result held, rsp_valid=1).
- can_accept = (state == EMPTY) || rsp_ready.
- Arbitration: search req_valid starting at index (last+1) mod NREQ, ascending with wrap. The first set bit is the winner. req_ready[winner] = can_accept. All other req_ready bits are 0. When no req_valid is set or can_accept=0, req_ready is all zero.
- req_ready depends on req_valid and rsp_ready combinationally. Requesters must not make req_valid depend on req_ready.
- Accept = |(req_valid & req_ready). On accept:
  - register {rsp_carry, rsp_sum} = zero-extended a + b, computed at WIDTH+1 bits with no truncation of the carry
  - rsp_id = winner
  - last = winner
  - next state FULL
- FULL with rsp_ready=1 and no new accept: next state EMPTY.
- FULL with rsp_ready=1 and new accept: stay FULL and load the new result (back-to-back, one result per cycle).
- FULL with rsp_ready=0: outputs hold stable; no grant.
- A requester whose req_valid drops before being granted loses nothing; there is no state kept per requester.
- last is updated only on accept, so a requester that stops requesting does not shift fairness.

## Timing
- Reset (rst_n=0, asynchronous): state=EMPTY, rsp_valid=0, busy=0, rsp_sum=0, rsp_carry=0, rsp_id=0, last=NREQ-1 (so index 0 has first priority). req_ready=0 during reset.
- Latency: accept on edge N -> rsp_valid=1 with result after edge N, visible in cycle N+1.
- Throughput: 1 transaction per cycle while rsp_ready=1.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. Maximum wait is NREQ-1 accepts.
- Reset asserted mid-transaction: the held result is discarded, and rsp_valid drops immediately (asynchronously).
- Wrap-around: arbitration search wraps from NREQ-1 to 0. last wraps identically.

## Test plan
- Reset then single request: req_valid=4'b0010, a1=8'hF0, b1=8'h20 -> req_ready=4'b0010 the same cycle. Next cycle: rsp_valid=1, rsp_id=1, rsp_sum=8'h10, rsp_carry=1.
- All valid with rsp_ready=1 held for 8 cycles -> grants 0,1,2,3,0,1,2,3. Each result tag matches its grant, e.g. a_i=i, b_i=8'h10 gives sum 8'h10+i, carry 0.
- Backpressure: result held, rsp_ready=0 for 3 cycles with requests pending -> req_ready=0 and rsp_* stable. On rsp_ready=1, the next winner is granted the same cycle and the new result follows on the next cycle.
- Boundary arithmetic: a=8'hFF, b=8'hFF -> sum 8'hFE, carry 1. a=0, b=0 -> sum 0, carry 0. a=8'hFF, b=1 -> sum 0, carry 1.
- Fairness skip: last=1, req_valid=4'b0011 -> grant 0 (search 2,3, then wrap to 0). Next accept grants 1.
- Asynchronous reset mid-FULL: rst_n pulsed low between edges -> rsp_valid drops immediately. After release, index 0 has first priority.

Source files
------------

// File: rtl/adder_rr_if.sv
// Bundles the requester-side operand channel and the response channel of the
// shared adder. The master side drives requests and consumes responses.
interface adder_rr_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin arbiter in front of one registered WIDTH-bit adder. The winning
// requester's operands are summed on accept and returned tagged with its index.
//
//   state | meaning
//   EMPTY | no result held, any valid requester may be granted
//   FULL  | result held on rsp_*; a new grant only when rsp_ready consumes it
module adder_rr_scheduler #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input logic        clk,
  input logic        rst_n,
  adder_rr_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [NREQ-1:0]  grant;
  logic [NREQ*WIDTH-1:0] a_shift;
  logic [NREQ*WIDTH-1:0] b_shift;
  logic [WIDTH:0]   sum_ext;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_carry_q;

  // Reset gating keeps grants off while the block is held in reset.
  assign can_accept = rst_n && ((state == EMPTY) || bus.rsp_ready);

  // Search for the first valid requester starting just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // One-hot ready to the winner only; operands of the winner feed the adder.
  always_comb begin
    grant   = (found && can_accept) ? (NREQ'(1) << winner) : '0;
    accept  = |(bus.req_valid & grant);
    a_shift = bus.req_a >> (int'(winner) * WIDTH);
    b_shift = bus.req_b >> (int'(winner) * WIDTH);
    sum_ext = {1'b0, a_shift[WIDTH-1:0]} + {1'b0, b_shift[WIDTH-1:0]};
  end

  // Response FSM: load a result on accept, release it when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      last        <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state       <= FULL;
            rsp_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (!accept && bus.rsp_ready) begin
            state       <= EMPTY;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          rsp_valid_q <= 1'b0;
        end
      endcase
      if (accept) begin
        rsp_sum_q   <= sum_ext[WIDTH-1:0];
        rsp_carry_q <= sum_ext[WIDTH];
        rsp_id_q    <= winner;
        last        <= winner;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a rotating-priority-list model
// compared against the DUT every falling edge, plus literal spot checks.
module tb_adder_rr_scheduler;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BUSW  = NREQ * WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  adder_rr_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  adder_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: priority order list, rotated to start after each winner.
  bit m_full;
  int m_id;
  int m_sum;
  int m_order[NREQ];
  int m_pick;
  bit m_can;

  function automatic int model_pick(input logic [NREQ-1:0] v, input int ord[NREQ]);
    for (int k = 0; k < NREQ; k++)
      if (((v >> ord[k]) & NREQ'(1)) != '0) return ord[k];
    return -1;
  endfunction

  function automatic int op(input logic [BUSW-1:0] v, input int i);
    logic [BUSW-1:0] t;
    t = v >> (i * WIDTH);
    return int'(t[WIDTH-1:0]);
  endfunction

  always_comb begin
    m_pick = model_pick(bus.req_valid, m_order);
    m_can  = !m_full || bus.rsp_ready;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_id   <= 0;
      m_sum  <= 0;
      for (int k = 0; k < NREQ; k++) m_order[k] <= k;
    end else if (m_can && m_pick >= 0) begin
      m_full <= 1'b1;
      m_id   <= m_pick;
      m_sum  <= op(bus.req_a, m_pick) + op(bus.req_b, m_pick);
      for (int k = 0; k < NREQ; k++) m_order[k] <= (m_pick + 1 + k) % NREQ;
    end else if (m_full && bus.rsp_ready) begin
      m_full <= 1'b0;
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    end else begin
      chk("m_req_ready", 32'(bus.req_ready), (m_can && m_pick >= 0) ? (1 << m_pick) : 0);
      chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
      chk("m_busy", 32'(bus.busy), 32'(m_full));
      if (m_full) begin
        chk("m_rsp_id", 32'(bus.rsp_id), m_id);
        chk("m_rsp_sum", 32'(bus.rsp_sum), m_sum % 256);
        chk("m_rsp_carry", 32'(bus.rsp_carry), m_sum / 256);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [BUSW-1:0] mask;
    mask = {{(BUSW-WIDTH){1'b0}}, {WIDTH{1'b1}}} << (i * WIDTH);
    bus.req_a = (bus.req_a & ~mask) | ({{(BUSW-WIDTH){1'b0}}, a} << (i * WIDTH));
    bus.req_b = (bus.req_b & ~mask) | ({{(BUSW-WIDTH){1'b0}}, b} << (i * WIDTH));
  endtask

  task automatic run_one(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
    set_op(i, a, b);
    bus.req_valid = NREQ'(1) << i;
    bus.rsp_ready = 1'b1;
    step();
    bus.req_valid = '0;
    #1;
    chk("lit_one_id", 32'(bus.rsp_id), i);
    chk("lit_one_sum", 32'(bus.rsp_sum), 32'(es));
    chk("lit_one_carry", 32'(bus.rsp_carry), 32'(ec));
    step();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_valid", 32'(bus.rsp_valid), 0);
    chk("lit_rst_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;

    // single request on requester 1
    set_op(1, 8'hF0, 8'h20);
    bus.req_valid = 4'b0010;
    #1;
    chk("lit_single_grant", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    #1;
    chk("lit_single_valid", 32'(bus.rsp_valid), 1);
    chk("lit_single_id", 32'(bus.rsp_id), 1);
    chk("lit_single_sum", 32'(bus.rsp_sum), 32'h10);
    chk("lit_single_carry", 32'(bus.rsp_carry), 1);
    bus.rsp_ready = 1'b1;
    step();
    chk("lit_drain", 32'(bus.rsp_valid), 0);

    // fresh reset, then all requesters valid
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i), 8'h10);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("lit_rr_grant", 32'(bus.req_ready), 1 << (k % 4));
      if (k > 0) begin
        chk("lit_rr_id", 32'(bus.rsp_id), (k - 1) % 4);
        chk("lit_rr_sum", 32'(bus.rsp_sum), 32'h10 + (k - 1) % 4);
      end
      step();
    end

    // backpressure with requests pending
    bus.rsp_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("lit_bp_ready", 32'(bus.req_ready), 0);
      chk("lit_bp_id", 32'(bus.rsp_id), 3);
      chk("lit_bp_sum", 32'(bus.rsp_sum), 32'h13);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("lit_bp_release", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    #1;
    chk("lit_bp_next_id", 32'(bus.rsp_id), 0);
    chk("lit_bp_next_sum", 32'(bus.rsp_sum), 32'h10);
    step();

    // boundary arithmetic
    run_one(0, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_one(2, 8'h00, 8'h00, 8'h00, 1'b0);
    run_one(3, 8'hFF, 8'h01, 8'h00, 1'b1);

    // fairness skip: last = 1, requesters 0 and 1 valid
    run_one(1, 8'h05, 8'h06, 8'h0B, 1'b0);
    set_op(0, 8'h01, 8'h02);
    set_op(1, 8'h03, 8'h04);
    bus.req_valid = 4'b0011;
    #1;
    chk("lit_skip_grant0", 32'(bus.req_ready), 1);
    step();
    #1;
    chk("lit_skip_grant1", 32'(bus.req_ready), 2);
    chk("lit_skip_sum0", 32'(bus.rsp_sum), 3);
    step();
    bus.req_valid = '0;
    #1;
    chk("lit_skip_id1", 32'(bus.rsp_id), 1);
    chk("lit_skip_sum1", 32'(bus.rsp_sum), 7);
    step();

    // asynchronous reset while a result is held
    set_op(2, 8'h80, 8'h80);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    #1;
    chk("lit_full_valid", 32'(bus.rsp_valid), 1);
    chk("lit_full_carry", 32'(bus.rsp_carry), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("lit_async_valid", 32'(bus.rsp_valid), 0);
    chk("lit_async_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    step();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    chk("lit_post_rst_grant", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    #1;
    chk("lit_post_rst_id", 32'(bus.rsp_id), 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
